// File: rtl/stopwatch_pkg.sv
// Shared encodings for the stopwatch sequencer: FSM states and key indices.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

  localparam int unsigned NUM_KEYS    = 4;
  localparam int unsigned K_STARTSTOP = 3;
  localparam int unsigned K_PAUSE     = 2;
  localparam int unsigned K_FREEZE    = 1;
  localparam int unsigned K_UNFREEZE  = 0;

endpackage

// File: rtl/key_debounce.sv
// One active-low key: 2-FF synchroniser, stability counter and a one-cycle
// press pulse on each accepted 1->0 level change.
module key_debounce #(
  parameter int unsigned DB_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n_i,
  output logic press_o
);

  localparam int unsigned CW = $clog2(DB_CYCLES + 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= key_n_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  // Counter restarts whenever the sample agrees with the accepted level.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    press_d = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CW'(DB_CYCLES - 1)) begin
        level_d = sync2_q;
        press_d = ~sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: key debouncing, IDLE/RUN/PAUSE control, centisecond
// prescaler and single-cycle clear/increment/display-load commands.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned DB_CYCLES = 500000,
  parameter int unsigned TICK_DIV  = 500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key3,
  input  logic       key2,
  input  logic       key1,
  input  logic       key0,
  output logic       cnt_clear,
  output logic       cnt_inc,
  output logic       disp_load,
  output logic [1:0] state,
  output logic       frozen
);

  localparam int unsigned PW = $clog2(TICK_DIV);

  logic [NUM_KEYS-1:0] key_n;
  logic [NUM_KEYS-1:0] ev_raw;
  logic [NUM_KEYS-1:0] ev;

  state_e        state_q, state_d;
  logic          frozen_q, frozen_d;
  logic          load_q, load_d;
  logic [PW-1:0] presc_q, presc_d;

  assign key_n = {key3, key2, key1, key0};

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    key_debounce #(
      .DB_CYCLES(DB_CYCLES)
    ) u_db (
      .clk     (clk),
      .rst     (rst),
      .key_n_i (key_n[g]),
      .press_o (ev_raw[g])
    );
  end

  // Only the highest-priority event of a cycle survives.
  always_comb begin
    ev = '0;
    if (ev_raw[K_STARTSTOP])     ev[K_STARTSTOP] = 1'b1;
    else if (ev_raw[K_PAUSE])    ev[K_PAUSE]     = 1'b1;
    else if (ev_raw[K_FREEZE])   ev[K_FREEZE]    = 1'b1;
    else if (ev_raw[K_UNFREEZE]) ev[K_UNFREEZE]  = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      frozen_q <= 1'b0;
      load_q   <= 1'b0;
      presc_q  <= '0;
    end else begin
      state_q  <= state_d;
      frozen_q <= frozen_d;
      load_q   <= load_d;
      presc_q  <= presc_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    frozen_d  = frozen_q;
    presc_d   = presc_q;
    load_d    = 1'b0;
    cnt_clear = 1'b0;
    cnt_inc   = (state_q == ST_RUN) && (presc_q == PW'(TICK_DIV - 1));

    case (state_q)
      ST_IDLE: begin
        presc_d = '0;
        if (ev[K_STARTSTOP]) begin
          state_d   = ST_RUN;
          cnt_clear = 1'b1;
        end
      end
      ST_RUN: begin
        presc_d = cnt_inc ? '0 : presc_q + PW'(1);
        load_d  = cnt_inc && !frozen_q;
        if (ev[K_STARTSTOP]) begin
          state_d   = ST_IDLE;
          cnt_clear = 1'b1;
          frozen_d  = 1'b0;
          presc_d   = '0;
        end else if (ev[K_PAUSE]) begin
          state_d = ST_PAUSE;
        end else if (ev[K_FREEZE]) begin
          frozen_d = 1'b1;
          load_d   = 1'b1;
        end else if (ev[K_UNFREEZE]) begin
          frozen_d = 1'b0;
        end
      end
      ST_PAUSE: begin
        if (ev[K_STARTSTOP]) begin
          state_d   = ST_IDLE;
          cnt_clear = 1'b1;
          frozen_d  = 1'b0;
          presc_d   = '0;
        end else if (ev[K_PAUSE]) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
        presc_d = '0;
      end
    endcase

    if (cnt_clear) load_d = 1'b0;
  end

  // A clear in the load cycle wins so the display is never loaded alongside it.
  assign disp_load = load_q & ~cnt_clear;
  assign state     = state_q;
  assign frozen    = frozen_q;

endmodule
